// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner tags
// and the fixed transfer size used by instruction fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [2:0] XFER_WORD = 3'b010;
    localparam int         CNT_W     = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that did not win the previous grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   req_if_i,
    input  logic   req_d_i,
    input  logic   grant_en_i,
    output logic   gnt_valid_o,
    output owner_e gnt_owner_o
);

    owner_e last_q;

    always_comb begin
        gnt_valid_o = req_if_i | req_d_i;
        gnt_owner_o = OWN_IF;
        if (req_if_i && req_d_i) begin
            gnt_owner_o = (last_q == OWN_IF) ? OWN_D : OWN_IF;
        end else if (req_d_i) begin
            gnt_owner_o = OWN_D;
        end
    end

    // Resetting to OWN_IF makes the data port win the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWN_IF;
        end else if (grant_en_i && gnt_valid_o) begin
            last_q <= gnt_owner_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester.
// Handshake: a requester holds req and arguments until its one-cycle valid/done pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_type,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_type,
    output logic        m_rd_en,
    output logic        m_wr_en,
    input  logic [31:0] m_rdata,
    output arb_state_e  dbg_state
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       type_q, type_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    logic   grant_en;
    logic   gnt_valid;
    owner_e gnt_owner;

    rr_arb2 u_rr_arb2 (
        .clk_i       (CLK),
        .rst_i       (Reset),
        .req_if_i    (if_req),
        .req_d_i     (d_req),
        .grant_en_i  (grant_en),
        .gnt_valid_o (gnt_valid),
        .gnt_owner_o (gnt_owner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        type_d     = type_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_en = 1'b1;
                    owner_d  = gnt_owner;
                    state_d  = ACCESS;
                    if (gnt_owner == OWN_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        type_d  = d_type;
                        wr_d    = d_wr;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        type_d  = XFER_WORD;
                        wr_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = wr_q ? RESP : WAIT;
            end
            WAIT: begin
                // Memory data is valid in the final latency cycle only.
                if (cnt_q == LAST_CNT) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_d = m_rdata;
                    end else begin
                        if_rdata_d = m_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            type_q     <= type_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Memory-side outputs decode from state so reset drops them without a clock.
    assign m_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign m_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign m_type  = (state_q == ACCESS) ? type_q  : '0;
    assign m_rd_en = (state_q == ACCESS) && !wr_q;
    assign m_wr_en = (state_q == ACCESS) && wr_q;

    assign if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_done    = (state_q == RESP) && (owner_q == OWN_D);
    assign if_stall  = if_req && !if_valid;
    assign d_stall   = d_req && !d_done;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1 and one at latency 3,
// each checked every cycle against a transaction-timeline model plus literal values.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic [31:0] m_rdata;
  } in_t;

  typedef struct packed {
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_type;
    logic        m_rd_en;
    logic        m_wr_en;
  } out_t;

  // k counts clock edges since the grant: 1 = memory access, then the latency
  // cycles for a read, then the response cycle.
  typedef struct {
    bit          busy;
    int          k;
    bit          own_d;
    bit          last_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
    bit          wr;
    logic [31:0] if_rd;
    logic [31:0] d_rd;
  } mdl_t;

  logic clk;
  logic rst = 1'b1;
  in_t  in1 = '0;
  in_t  in3 = '0;
  mdl_t m1, m3;
  out_t o1, o3, e1, e3;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [0:0] exp_q[$];

  logic [31:0] if_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        if_valid1, if_stall1, d_done1, d_stall1, m_rd_en1, m_wr_en1;
  logic [2:0]  m_type1;
  arb_state_e  st1;
  logic [31:0] if_rdata3, d_rdata3, m_addr3, m_wdata3;
  logic        if_valid3, if_stall3, d_done3, d_stall3, m_rd_en3, m_wr_en3;
  logic [2:0]  m_type3;
  arb_state_e  st3;

  assign o1 = {if_rdata1, if_valid1, if_stall1, d_rdata1, d_done1, d_stall1,
               m_addr1, m_wdata1, m_type1, m_rd_en1, m_wr_en1};
  assign o3 = {if_rdata3, if_valid3, if_stall3, d_rdata3, d_done3, d_stall3,
               m_addr3, m_wdata3, m_type3, m_rd_en3, m_wr_en3};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .CLK(clk), .Reset(rst),
    .if_req(in1.if_req), .if_addr(in1.if_addr), .if_rdata(if_rdata1),
    .if_valid(if_valid1), .if_stall(if_stall1),
    .d_req(in1.d_req), .d_wr(in1.d_wr), .d_addr(in1.d_addr), .d_wdata(in1.d_wdata),
    .d_type(in1.d_type), .d_rdata(d_rdata1), .d_done(d_done1), .d_stall(d_stall1),
    .m_addr(m_addr1), .m_wdata(m_wdata1), .m_type(m_type1), .m_rd_en(m_rd_en1),
    .m_wr_en(m_wr_en1), .m_rdata(in1.m_rdata), .dbg_state(st1)
  );

  mem_arbiter #(.MEM_LAT(3)) dut3 (
    .CLK(clk), .Reset(rst),
    .if_req(in3.if_req), .if_addr(in3.if_addr), .if_rdata(if_rdata3),
    .if_valid(if_valid3), .if_stall(if_stall3),
    .d_req(in3.d_req), .d_wr(in3.d_wr), .d_addr(in3.d_addr), .d_wdata(in3.d_wdata),
    .d_type(in3.d_type), .d_rdata(d_rdata3), .d_done(d_done3), .d_stall(d_stall3),
    .m_addr(m_addr3), .m_wdata(m_wdata3), .m_type(m_type3), .m_rd_en(m_rd_en3),
    .m_wr_en(m_wr_en3), .m_rdata(in3.m_rdata), .dbg_state(st3)
  );

  // ---------------- behavioural model ----------------
  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 0; m.k = 0; m.own_d = 0; m.last_d = 0;
    m.addr = '0; m.wdata = '0; m.typ = '0; m.wr = 0;
    m.if_rd = '0; m.d_rd = '0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, in_t x, int lat);
    mdl_t n;
    int   resp;
    n = m;
    resp = m.wr ? 2 : lat + 2;
    if (m.busy) begin
      if (m.k == resp) begin
        n.busy = 0;
      end else begin
        if (!m.wr && m.k == lat + 1) begin
          if (m.own_d) n.d_rd = x.m_rdata;
          else n.if_rd = x.m_rdata;
        end
        n.k = m.k + 1;
      end
    end else if (x.if_req || x.d_req) begin
      n.own_d  = (x.if_req && x.d_req) ? !m.last_d : x.d_req;
      n.last_d = n.own_d;
      n.busy   = 1;
      n.k      = 1;
      if (n.own_d) begin
        n.addr = x.d_addr; n.wdata = x.d_wdata; n.typ = x.d_type; n.wr = x.d_wr;
      end else begin
        n.addr = x.if_addr; n.wdata = '0; n.typ = 3'b010; n.wr = 0;
      end
    end
    return n;
  endfunction

  function automatic out_t mdl_out(mdl_t m, in_t x, int lat);
    out_t o;
    int   resp;
    o = '0;
    resp = m.wr ? 2 : lat + 2;
    o.if_rdata = m.if_rd;
    o.d_rdata  = m.d_rd;
    if (m.busy && m.k == 1) begin
      o.m_addr  = m.addr;
      o.m_wdata = m.wdata;
      o.m_type  = m.typ;
      o.m_rd_en = !m.wr;
      o.m_wr_en = m.wr;
    end
    if (m.busy && m.k == resp) begin
      o.if_valid = !m.own_d;
      o.d_done   = m.own_d;
    end
    o.if_stall = x.if_req && !o.if_valid;
    o.d_stall  = x.d_req && !o.d_done;
    return o;
  endfunction

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m1 = mdl_reset();
        m3 = mdl_reset();
      end else begin
        m1 = mdl_step(m1, in1, 1);
        m3 = mdl_step(m3, in3, 3);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      e1 = mdl_out(m1, in1, 1);
      e3 = mdl_out(m3, in3, 3);
      n_chk++;
      if (o1 !== e1) begin
        n_fail++;
        $display("FAIL model_lat1 @%0t: got %h expected %h", $time, o1, e1);
      end
      n_chk++;
      if (o3 !== e3) begin
        n_fail++;
        $display("FAIL model_lat3 @%0t: got %h expected %h", $time, o3, e3);
      end
    end
  endtask

  // ---------------- driver / directed tests ----------------
  task automatic next_cycle_inputs();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int got;
    int wait_cnt;
    m1 = mdl_reset();
    m3 = mdl_reset();
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_lat1", {31'b0, |o1}, 32'd0);
    chk("reset_out_lat3", {31'b0, |o3}, 32'd0);
    chk("reset_state", 32'(st1), 32'(IDLE));

    // Fetch read at latency 1.
    next_cycle_inputs();
    in1.if_req = 1'b1; in1.if_addr = 32'h40; in1.m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("fetch_stall_t", {31'b0, if_stall1}, 32'd1);
    @(negedge clk);
    chk("fetch_rd_en_t1", {31'b0, m_rd_en1}, 32'd1);
    chk("fetch_addr_t1", m_addr1, 32'h40);
    chk("fetch_type_t1", {29'b0, m_type1}, 32'd2);
    @(negedge clk);
    chk("fetch_no_valid_t2", {31'b0, if_valid1}, 32'd0);
    @(negedge clk);
    chk("fetch_valid_t3", {31'b0, if_valid1}, 32'd1);
    chk("fetch_rdata_t3", if_rdata1, 32'hDEADBEEF);
    chk("fetch_stall_t3", {31'b0, if_stall1}, 32'd0);
    next_cycle_inputs();
    in1.if_req = 1'b0;

    // Data write at latency 1.
    next_cycle_inputs();
    in1.d_req = 1'b1; in1.d_wr = 1'b1; in1.d_addr = 32'h100;
    in1.d_wdata = 32'h12345678; in1.d_type = 3'b001;
    @(negedge clk);
    chk("wr_rd_en_t", {31'b0, m_rd_en1}, 32'd0);
    @(negedge clk);
    chk("wr_wr_en_t1", {31'b0, m_wr_en1}, 32'd1);
    chk("wr_rd_en_t1", {31'b0, m_rd_en1}, 32'd0);
    chk("wr_addr_t1", m_addr1, 32'h100);
    chk("wr_wdata_t1", m_wdata1, 32'h12345678);
    chk("wr_type_t1", {29'b0, m_type1}, 32'd1);
    @(negedge clk);
    chk("wr_done_t2", {31'b0, d_done1}, 32'd1);
    chk("wr_wr_en_t2", {31'b0, m_wr_en1}, 32'd0);
    next_cycle_inputs();
    in1.d_req = 1'b0; in1.d_wr = 1'b0;

    // Data read whose request drops right after the grant.
    next_cycle_inputs();
    in1.d_req = 1'b1; in1.d_addr = 32'h200; in1.m_rdata = 32'h0BADF00D;
    next_cycle_inputs();
    in1.d_req = 1'b0; in1.d_addr = 32'hFFFFFFFF;
    @(negedge clk);
    chk("drop_addr_t1", m_addr1, 32'h200);
    chk("drop_rd_en_t1", {31'b0, m_rd_en1}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("drop_done_t3", {31'b0, d_done1}, 32'd1);
    chk("drop_rdata_t3", d_rdata1, 32'h0BADF00D);
    @(negedge clk);
    chk("drop_done_t4", {31'b0, d_done1}, 32'd0);
    @(negedge clk);
    chk("drop_done_t5", {31'b0, d_done1}, 32'd0);

    // Reset, then both requesters held: data must win first, then alternate.
    next_cycle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_clears_rdata", if_rdata1, 32'd0);
    next_cycle_inputs();
    in1.if_req = 1'b1; in1.if_addr = 32'h400;
    in1.d_req = 1'b1; in1.d_wr = 1'b0; in1.d_addr = 32'h300;
    in1.m_rdata = 32'h55AA55AA;
    exp_q = {1'b1, 1'b0, 1'b1, 1'b0};
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (d_done1 || if_valid1) begin
        chk("rr_order_is_d", {31'b0, d_done1}, {31'b0, exp_q.pop_front()});
        got++;
      end
    end
    chk("rr_completions", got, 32'd4);
    next_cycle_inputs();
    in1.if_req = 1'b0; in1.d_req = 1'b0;
    chk("rr_if_rdata", if_rdata1, 32'h55AA55AA);
    chk("rr_d_rdata", d_rdata1, 32'h55AA55AA);

    // Latency 3 read; memory data changes every cycle.
    next_cycle_inputs();
    in3.d_req = 1'b1; in3.d_wr = 1'b0; in3.d_addr = 32'h500; in3.m_rdata = 32'hA0000000;
    wait_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (st3 == WAIT) wait_cnt++;
      chk("lat3_done", {31'b0, d_done3}, (k == 5) ? 32'd1 : 32'd0);
      chk("lat3_rd_en", {31'b0, m_rd_en3}, (k == 1) ? 32'd1 : 32'd0);
      if (k == 5) chk("lat3_rdata", d_rdata3, 32'hA0000004);
      next_cycle_inputs();
      in3.m_rdata = 32'hA0000000 + 32'(k + 1);
      if (k == 5) in3.d_req = 1'b0;
    end
    chk("lat3_wait_cycles", wait_cnt, 32'd3);

    // Reset in the middle of a latency-3 wait.
    next_cycle_inputs();
    in3.d_req = 1'b1; in3.d_addr = 32'h600; in3.m_rdata = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_in_wait", 32'(st3), 32'(WAIT));
    #1 rst = 1'b1; in3.d_req = 1'b0;
    #1;
    chk("rstw_outputs_zero", {31'b0, |o3}, 32'd0);
    chk("rstw_state", 32'(st3), 32'(IDLE));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    next_cycle_inputs();
    in3.d_req = 1'b1; in3.d_wr = 1'b1; in3.d_addr = 32'h700;
    in3.d_wdata = 32'h0000CAFE; in3.d_type = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_fresh_wr_en", {31'b0, m_wr_en3}, 32'd1);
    chk("rstw_fresh_addr", m_addr3, 32'h700);
    @(negedge clk);
    chk("rstw_fresh_done", {31'b0, d_done3}, 32'd1);
    next_cycle_inputs();
    in3.d_req = 1'b0; in3.d_wr = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
